// File: rtl/hbm_rd_arbiter_if.sv
// Requester-side and HBM-side AXI read bundle for hbm_rd_arbiter.
//   s_*      : N_REQ requester AR/R channels, flattened, requester i in slice i
//   m_axi_*  : single wide HBM read port
// Modports:
//   slave  - the arbiter's view (takes requests, drives HBM AR, steers R)
//   master - the environment's view (requesters + HBM model)
interface hbm_rd_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 512
);
    logic [N_REQ*ADDR_BITS-1:0] s_araddr;
    logic [N_REQ*8-1:0]         s_arlen;
    logic [N_REQ-1:0]           s_arvalid;
    logic [N_REQ-1:0]           s_arready;
    logic [DATA_BITS-1:0]       s_rdata;
    logic                       s_rlast;
    logic [1:0]                 s_rresp;
    logic [N_REQ-1:0]           s_rvalid;
    logic [N_REQ-1:0]           s_rready;

    logic [ADDR_BITS-1:0]       m_axi_araddr;
    logic [7:0]                 m_axi_arlen;
    logic                       m_axi_arvalid;
    logic                       m_axi_arready;
    logic [DATA_BITS-1:0]       m_axi_rdata;
    logic                       m_axi_rlast;
    logic [1:0]                 m_axi_rresp;
    logic                       m_axi_rvalid;
    logic                       m_axi_rready;

    modport slave (
        input  s_araddr, s_arlen, s_arvalid, s_rready,
               m_axi_arready, m_axi_rdata, m_axi_rlast, m_axi_rresp, m_axi_rvalid,
        output s_arready, s_rdata, s_rlast, s_rresp, s_rvalid,
               m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
    );

    modport master (
        output s_araddr, s_arlen, s_arvalid, s_rready,
               m_axi_arready, m_axi_rdata, m_axi_rlast, m_axi_rresp, m_axi_rvalid,
        input  s_arready, s_rdata, s_rlast, s_rresp, s_rvalid,
               m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_rready
    );
endinterface

// File: rtl/hbm_rd_arbiter.sv
// Round-robin read arbiter sharing one wide HBM read port among N_REQ
// requesters. Grants are recorded in a routing FIFO (requester index + arlen)
// and R beats are steered back to the FIFO head's requester; bursts come
// back in issue order so no ID remapping is done.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   bus          : hbm_rd_arbiter_if.slave (requester AR/R, HBM AR/R)
//   len_err      : sticky, an R burst's beat count disagreed with its arlen
//   outst_cnt    : bursts issued whose last beat has not returned (= FIFO occupancy)
module hbm_rd_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 512,
    parameter int MAX_OUTST = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    hbm_rd_arbiter_if.slave              bus,
    output logic                         len_err,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_nx;
    logic [GW-1:0]        rr_ptr, gnt_idx, head_g;
    logic                 gnt_found, grant, full, empty, r_hs, pop;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [GW-1:0]        fifo_g   [MAX_OUTST];
    logic [7:0]           fifo_len [MAX_OUTST];
    logic [7:0]           head_len, ar_len;
    logic [8:0]           beat_cnt;
    logic [ADDR_BITS-1:0] ar_addr;
    logic [DATA_BITS-1:0] r_data;

    // Full is taken from the registered count, so a pop on a full FIFO
    // only opens a slot for the following cycle.
    assign full  = (outst_cnt == CW'(MAX_OUTST));
    assign empty = (outst_cnt == '0);

    // First requester at or after rr_ptr. Scan from the far end so the
    // closest one to rr_ptr is the last to write gnt_idx.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.s_arvalid[(int'(rr_ptr) + k) % N_REQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && !full && !areset) begin
                    grant    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_axi_arready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.s_arready     = grant ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.m_axi_arvalid = (state == ISSUE);
    assign bus.m_axi_araddr  = ar_addr;
    assign bus.m_axi_arlen   = ar_len;

    // R steering: head of the routing FIFO owns the R channel.
    assign head_g           = fifo_g[rd_ptr];
    assign head_len         = fifo_len[rd_ptr];
    assign bus.m_axi_rready = !empty && bus.s_rready[head_g];
    assign bus.s_rvalid     = (!empty && bus.m_axi_rvalid) ? (N_REQ'(1) << head_g) : '0;
    assign r_data           = bus.m_axi_rdata;
    assign bus.s_rdata      = r_data;
    assign bus.s_rlast      = bus.m_axi_rlast;
    assign bus.s_rresp      = bus.m_axi_rresp;
    assign r_hs             = bus.m_axi_rvalid && bus.m_axi_rready;
    assign pop              = r_hs && bus.m_axi_rlast;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            outst_cnt <= '0;
            beat_cnt  <= '0;
            len_err   <= 1'b0;
            ar_addr   <= '0;
            ar_len    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                ar_addr <= bus.s_araddr[gnt_idx*ADDR_BITS +: ADDR_BITS];
                ar_len  <= bus.s_arlen[gnt_idx*8 +: 8];
                rr_ptr  <= (gnt_idx == GW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                wr_ptr  <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({grant, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: ;
            endcase
            if (r_hs) beat_cnt <= bus.m_axi_rlast ? '0 : beat_cnt + 1'b1;
            // Short burst: rlast before count reaches arlen. Overrun: a
            // non-last beat at or past arlen, i.e. the count exceeds arlen.
            if (r_hs && (bus.m_axi_rlast ? (beat_cnt != {1'b0, head_len})
                                         : (beat_cnt >= {1'b0, head_len})))
                len_err <= 1'b1;
        end
    end

    // Routing memory needs no reset; the pointers define validity.
    always_ff @(posedge aclk) begin
        if (grant) begin
            fifo_g[wr_ptr]   <= gnt_idx;
            fifo_len[wr_ptr] <= bus.s_arlen[gnt_idx*8 +: 8];
        end
    end

    a_arready_onehot: assert property (@(posedge aclk) disable iff (areset)
        $onehot0(bus.s_arready));
    a_rvalid_onehot: assert property (@(posedge aclk) disable iff (areset)
        $onehot0(bus.s_rvalid));
    a_ar_stable: assert property (@(posedge aclk) disable iff (areset)
        (bus.m_axi_arvalid && !bus.m_axi_arready) |=>
            ($stable(bus.m_axi_araddr) && $stable(bus.m_axi_arlen)));
endmodule
